exwb_stage: RTL and testbench
=============================

Name: exwb_stage

Overview:
- EX/WB pipeline register plus writeback into the 2-read/1-write architectural register file.
- Captures the EX result each cycle and presents exwb_valid/exwb_regwrite/exwb_dst/exwb_result to the forwarding unit and the EX operand bypass mux.
- Commits the held result into the register file one cycle later.
- Serves the ID stage's two register read ports and counts retired instructions.

Parameters:
- DATA_W, 8, datapath/register width in bits
- REG_ADDR_W, 3, register address width; NUM_REGS = 2**REG_ADDR_W
- CNT_W, 16, retire counter width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX stage holds a valid instruction this cycle
- ex_regwrite  input  1  instruction writes a destination register
- ex_dst  input  REG_ADDR_W  destination register address
- ex_result  input  DATA_W  ALU/EX result
- hold  input  1  stall WB: EX/WB register and register file frozen
- flush  input  1  squash instruction entering EX/WB this edge
- ex_ready  output  1  EX/WB accepts a new instruction this edge (= !hold)
- exwb_valid  output  1  EX/WB register holds a valid instruction
- exwb_regwrite  output  1  held instruction writes a register (forced 0 when !exwb_valid)
- exwb_dst  output  REG_ADDR_W  held destination address
- exwb_result  output  DATA_W  held result
- rs_addr  input  REG_ADDR_W  ID read port A address
- rs_data  output  DATA_W  read port A data (combinational)
- rt_addr  input  REG_ADDR_W  ID read port B address
- rt_data  output  DATA_W  read port B data (combinational)
- retire_count  output  CNT_W  number of instructions retired

Behaviour:
- Reset (rst_n=0, asynchronous): exwb_valid, exwb_regwrite, exwb_dst, exwb_result, retire_count all 0; every register file entry 0. Reset mid-operation discards the held instruction with no write.
- Advance: wb_fire = !hold. On a rising edge with wb_fire=1:
  - exwb_valid <= ex_valid & !flush
  - exwb_regwrite <= ex_regwrite & ex_valid & !flush
  - exwb_dst <= ex_dst
  - exwb_result <= ex_result
- hold=1: all EX/WB fields keep their values; ex_ready=0; no register file write; counter unchanged.
- hold=1 with flush=1: hold wins; the flush is ignored that cycle. EX must re-present the flush with its held instruction.
- Latency: instruction present in EX in cycle N appears on exwb_* in cycle N+1. It is written to the register file at the end of N+1 (if not held) and is readable from the array in N+2.
- Commit write on an edge when wb_fire & exwb_valid & exwb_regwrite & (exwb_dst != 0): reg[exwb_dst] <= exwb_result.
- Register 0 always reads 0; writes to it are dropped but the instruction still retires.
- Read ports are combinational. rs_addr==rt_addr is legal; both return the same data.
- retire_count increments by 1 on each edge with wb_fire & exwb_valid, whether or not the instruction writes a register. Wraps from 2**CNT_W-1 to 0.
- Each held instruction commits exactly once: the write and count fire only on the edge that releases it.

Optional Feature:
- Macro: WB_READ_BYPASS_EN.
- Defined: rs_data/rt_data return exwb_result when the read address equals exwb_dst, exwb_valid & exwb_regwrite are set, and the address is non-zero. This write-through removes the WB-to-ID hazard in cycle N+1.
- Not defined: read ports return array contents only. The old value is returned until the commit edge; software or the hazard unit must cover the one-cycle gap.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and REG_ADDR_W constants
  - typedefs data_t and reg_addr_t
  - localparam ZERO_REG = 0
- Sub-module regfile_2r1w: storage array with asynchronous reset, one write port, two combinational read ports, zero-register rule, and the optional bypass.
- exwb_stage instantiates regfile_2r1w and holds the pipeline register and counter.

Test Plan:
- Reset, then ex_valid=1, regwrite=1, dst=3, result=0x5A -> next cycle exwb_valid=1, exwb_dst=3, exwb_result=0x5A. Following cycle rs_addr=3 reads 0x5A; retire_count=1.
- flush=1 with ex_valid=1, dst=2, result=0x11 -> exwb_valid=0, exwb_regwrite=0; reg2 stays 0x00; retire_count unchanged.
- Write dst=4, result=0x77, then hold=1 for 3 cycles -> exwb_* stable, ex_ready=0, reg4 still 0x00. After release, reg4=0x77 and retire_count increments by exactly 1.
- Write dst=0, result=0xFF -> rs_addr=0 reads 0x00; retire_count increments.
- With WB_READ_BYPASS_EN, exwb holding dst=5, result=0x3C, rt_addr=5 -> rt_data=0x3C in the same cycle. Without the macro, rt_data returns the old value 0x00.
- CNT_W=4, retire 17 instructions -> retire_count=1. Assert rst_n=0 mid-stream -> all outputs and registers 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the CPU pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // Architectural register that always reads as zero.
  localparam int ZERO_REG = 0;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/exwb_stage_if.sv
// EX/WB stage bundle: EX hand-off, held WB state, ID read ports, retire count.
// Latency: n/a (wires only).
// Backpressure: ex_ready low (hold) means EX must keep presenting its instruction.
interface exwb_stage_if #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
);

  logic                  ex_valid;
  logic                  ex_regwrite;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic [DATA_W-1:0]     ex_result;
  logic                  hold;
  logic                  flush;
  logic                  ex_ready;

  logic                  exwb_valid;
  logic                  exwb_regwrite;
  logic [REG_ADDR_W-1:0] exwb_dst;
  logic [DATA_W-1:0]     exwb_result;

  logic [REG_ADDR_W-1:0] rs_addr;
  logic [DATA_W-1:0]     rs_data;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0]     rt_data;

  logic [CNT_W-1:0]      retire_count;

  // Pipeline / ID side: drives the instruction, stall controls and read addresses.
  modport master (
    output ex_valid, ex_regwrite, ex_dst, ex_result, hold, flush, rs_addr, rt_addr,
    input  ex_ready, exwb_valid, exwb_regwrite, exwb_dst, exwb_result,
    input  rs_data, rt_data, retire_count
  );

  // Stage side: consumes the instruction and returns held state and read data.
  modport slave (
    input  ex_valid, ex_regwrite, ex_dst, ex_result, hold, flush, rs_addr, rt_addr,
    output ex_ready, exwb_valid, exwb_regwrite, exwb_dst, exwb_result,
    output rs_data, rt_data, retire_count
  );

endinterface

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file; register 0 hard-wired to zero. Macro: WB_READ_BYPASS_EN.
// Latency: reads combinational; a write is visible from the array the cycle after its edge.
// Backpressure: none; writes happen whenever we is set (caller gates with stall).
module regfile_2r1w #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0]     rs_data,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rt_data,
  input  logic                  byp_vld,
  input  logic [REG_ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0]     byp_data
);
  import cpu_pkg::ZERO_REG;

  localparam int NREGS = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [NREGS];
  logic              rs_hit;
  logic              rt_hit;

  // Storage: cleared on reset; writes to the zero register are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != ZERO_ADDR)) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef WB_READ_BYPASS_EN
  // Write-through: a result waiting in WB is returned before it lands in the array.
  assign rs_hit = byp_vld && (rs_addr == byp_addr) && (rs_addr != ZERO_ADDR);
  assign rt_hit = byp_vld && (rt_addr == byp_addr) && (rt_addr != ZERO_ADDR);
`else
  // Array-only reads; the WB-to-ID hazard is covered outside this block.
  logic unused_byp;
  assign unused_byp = ^{byp_vld, byp_addr, byp_data};
  assign rs_hit = 1'b0;
  assign rt_hit = 1'b0;
`endif

  // Read port A: zero register, then bypass, then array.
  always_comb begin
    rs_data = mem[rs_addr];
    if (rs_addr == ZERO_ADDR) begin
      rs_data = '0;
    end else if (rs_hit) begin
      rs_data = byp_data;
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    rt_data = mem[rt_addr];
    if (rt_addr == ZERO_ADDR) begin
      rt_data = '0;
    end else if (rt_hit) begin
      rt_data = byp_data;
    end
  end

endmodule

// File: rtl/exwb_stage.sv
// EX/WB pipeline register, register-file commit and retire counter. Macro: WB_READ_BYPASS_EN.
// Latency: EX in cycle N shows on exwb_* in N+1, commits at end of N+1, array-readable in N+2.
// Backpressure: hold freezes EX/WB, register file and counter; ex_ready = !hold.
module exwb_stage #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         rst_n,
  exwb_stage_if.slave bus
);
  import cpu_pkg::ZERO_REG;

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  logic                  wb_fire;
  logic                  commit_we;
  logic                  valid_q;
  logic                  regwrite_q;
  logic [REG_ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0]     result_q;
  logic [CNT_W-1:0]      retire_q;

  assign wb_fire     = !bus.hold;
  assign bus.ex_ready = wb_fire;

  // Held instruction writes back only on the edge that releases it.
  assign commit_we = wb_fire && valid_q && regwrite_q && (dst_q != ZERO_ADDR);

  // EX/WB register: advance unless held; flush squashes the incoming instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      dst_q      <= '0;
      result_q   <= '0;
    end else if (wb_fire) begin
      valid_q    <= bus.ex_valid && !bus.flush;
      regwrite_q <= bus.ex_regwrite && bus.ex_valid && !bus.flush;
      dst_q      <= bus.ex_dst;
      result_q   <= bus.ex_result;
    end
  end

  // Retire counter: one per released valid instruction, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else if (wb_fire && valid_q) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign bus.exwb_valid    = valid_q;
  assign bus.exwb_regwrite = regwrite_q;
  assign bus.exwb_dst      = dst_q;
  assign bus.exwb_result   = result_q;
  assign bus.retire_count  = retire_q;

  regfile_2r1w #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (commit_we),
    .waddr    (dst_q),
    .wdata    (result_q),
    .rs_addr  (bus.rs_addr),
    .rs_data  (bus.rs_data),
    .rt_addr  (bus.rt_addr),
    .rt_data  (bus.rt_data),
    .byp_vld  (valid_q && regwrite_q),
    .byp_addr (dst_q),
    .byp_data (result_q)
  );

endmodule

// File: tb/tb_exwb_stage.sv
// Bench for exwb_stage: directed vector table, counter-wrap and reset sequences, random vs model.
// Latency: checks one cycle after each applied vector (#1 past the rising edge).
// Backpressure: hold is exercised both in the table and randomly.
module tb_exwb_stage;
  import cpu_pkg::*;

`ifdef WB_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  exwb_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(16)) bus ();
  exwb_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(4))  bus4 ();

  exwb_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(16)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  exwb_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(4)) dut4 (
    .clk (clk), .rst_n (rst_n), .bus (bus4)
  );

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus4.ex_valid    = bus.ex_valid;
  assign bus4.ex_regwrite = bus.ex_regwrite;
  assign bus4.ex_dst      = bus.ex_dst;
  assign bus4.ex_result   = bus.ex_result;
  assign bus4.hold        = bus.hold;
  assign bus4.flush       = bus.flush;
  assign bus4.rs_addr     = bus.rs_addr;
  assign bus4.rt_addr     = bus.rt_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input int d, input int r,
                       input logic h, input logic f, input int rs, input int rt);
    bus.ex_valid    = v;
    bus.ex_regwrite = w;
    bus.ex_dst      = reg_addr_t'(d);
    bus.ex_result   = data_t'(r);
    bus.hold        = h;
    bus.flush       = f;
    bus.rs_addr     = reg_addr_t'(rs);
    bus.rt_addr     = reg_addr_t'(rt);
  endtask

  // While reset is asserted every output and every register must read zero.
  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"},    32'(bus.exwb_valid), 0);
    chk({tag, "_regwrite"}, 32'(bus.exwb_regwrite), 0);
    chk({tag, "_dst"},      32'(bus.exwb_dst), 0);
    chk({tag, "_result"},   32'(bus.exwb_result), 0);
    chk({tag, "_count"},    32'(bus.retire_count), 0);
    chk({tag, "_count4"},   32'(bus4.retire_count), 0);
    for (int a = 0; a < NUM_REGS; a++) begin
      bus.rs_addr = reg_addr_t'(a);
      bus.rt_addr = reg_addr_t'(NUM_REGS - 1 - a);
      #1;
      chk($sformatf("%s_rs%0d", tag, a), 32'(bus.rs_data), 0);
      chk($sformatf("%s_rt%0d", tag, NUM_REGS - 1 - a), 32'(bus.rt_data), 0);
    end
  endtask

  // Reference model: architectural state after each edge.
  bit m_valid, m_regwrite;
  int m_dst, m_result, m_count;
  int m_regs [NUM_REGS];

  function automatic void model_reset();
    m_valid = 0; m_regwrite = 0; m_dst = 0; m_result = 0; m_count = 0;
    foreach (m_regs[i]) m_regs[i] = 0;
  endfunction

  function automatic void model_edge(bit v, bit w, int d, int r, bit h, bit f);
    if (h) return;
    if (m_valid) begin
      m_count++;
      if (m_regwrite && m_dst != 0) m_regs[m_dst] = m_result;
    end
    m_valid    = v && !f;
    m_regwrite = v && w && !f;
    m_dst      = d;
    m_result   = r;
  endfunction

  function automatic int model_read(int a);
    if (a == 0) return 0;
    if (BYP && m_valid && m_regwrite && m_dst == a) return m_result;
    return m_regs[a];
  endfunction

  typedef struct {
    logic v, w; reg_addr_t d; data_t r; logic h, f; reg_addr_t rs, rt;
    logic ev, ew; reg_addr_t ed; data_t er; data_t ers, ert; int ecnt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    data_t b77, b3c;
    b77 = BYP ? 8'h77 : 8'h00;
    b3c = BYP ? 8'h3C : 8'h00;
    //         v w d r      h f rs rt  ev ew ed er     ers    ert   cnt
    tbl[0]  = '{1,1,3,8'h5A,0,0,0,1,   1,1,3,8'h5A,8'h00,8'h00,0};
    tbl[1]  = '{0,0,0,8'h00,0,0,3,3,   0,0,0,8'h00,8'h5A,8'h5A,1};
    tbl[2]  = '{1,1,2,8'h11,0,1,2,3,   0,0,2,8'h11,8'h00,8'h5A,1};
    tbl[3]  = '{0,1,7,8'hAB,0,0,2,3,   0,0,7,8'hAB,8'h00,8'h5A,1};
    tbl[4]  = '{1,1,4,8'h77,0,0,3,2,   1,1,4,8'h77,8'h5A,8'h00,1};
    tbl[5]  = '{1,1,6,8'h99,1,1,3,4,   1,1,4,8'h77,8'h5A,b77,  1};
    tbl[6]  = '{1,1,6,8'h99,1,1,3,4,   1,1,4,8'h77,8'h5A,b77,  1};
    tbl[7]  = '{1,1,6,8'h99,1,1,3,4,   1,1,4,8'h77,8'h5A,b77,  1};
    tbl[8]  = '{0,0,0,8'h00,0,0,4,4,   0,0,0,8'h00,8'h77,8'h77,2};
    tbl[9]  = '{1,1,0,8'hFF,0,0,0,0,   1,1,0,8'hFF,8'h00,8'h00,2};
    tbl[10] = '{0,0,0,8'h00,0,0,0,3,   0,0,0,8'h00,8'h00,8'h5A,3};
    tbl[11] = '{1,0,5,8'h3C,0,0,5,5,   1,0,5,8'h3C,8'h00,8'h00,3};
    tbl[12] = '{0,0,0,8'h00,0,0,5,5,   0,0,0,8'h00,8'h00,8'h00,4};
    tbl[13] = '{1,1,5,8'h3C,0,0,1,5,   1,1,5,8'h3C,8'h00,b3c,  4};
    tbl[14] = '{0,0,0,8'h00,0,0,5,5,   0,0,0,8'h00,8'h3C,8'h3C,5};

    // Power-on reset.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].h, tbl[i].f, tbl[i].rs, tbl[i].rt);
      tick();
      chk($sformatf("t%0d_valid", i),    32'(bus.exwb_valid),    32'(tbl[i].ev));
      chk($sformatf("t%0d_regwrite", i), 32'(bus.exwb_regwrite), 32'(tbl[i].ew));
      chk($sformatf("t%0d_dst", i),      32'(bus.exwb_dst),      32'(tbl[i].ed));
      chk($sformatf("t%0d_result", i),   32'(bus.exwb_result),   32'(tbl[i].er));
      chk($sformatf("t%0d_ready", i),    32'(bus.ex_ready),      32'(!tbl[i].h));
      chk($sformatf("t%0d_rs", i),       32'(bus.rs_data),       32'(tbl[i].ers));
      chk($sformatf("t%0d_rt", i),       32'(bus.rt_data),       32'(tbl[i].ert));
      chk($sformatf("t%0d_count", i),    32'(bus.retire_count),  32'(tbl[i].ecnt));
      chk($sformatf("t%0d_count4", i),   32'(bus4.retire_count), 32'(tbl[i].ecnt % 16));
    end

    // Seventeen retirements: the 16-bit counter reads 17, the 4-bit one wraps to 1.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, i % NUM_REGS, 8'h20 + i, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap_count16", 32'(bus.retire_count), 17);
    chk("wrap_count4",  32'(bus4.retire_count), 1);

    // Reset asserted mid-stream with a writing instruction held in WB.
    drive(1, 1, 6, 8'hC3, 0, 0, 0, 0);
    tick();
    chk("mid_pre_valid", 32'(bus.exwb_valid), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 6, 6);
    rst_n = 1'b1;
    tick();
    chk("midrst_no_write6", 32'(bus.rs_data), 0);

    // Random traffic against the reference model, starting from reset.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bit v, w, h, f;
      int d, r, rs, rt;
      v  = ($urandom_range(3) != 0);
      w  = ($urandom_range(3) != 0);
      h  = ($urandom_range(3) == 0);
      f  = ($urandom_range(6) == 0);
      d  = $urandom_range(NUM_REGS - 1);
      r  = $urandom_range(255);
      rs = $urandom_range(NUM_REGS - 1);
      rt = ($urandom_range(3) == 0) ? rs : $urandom_range(NUM_REGS - 1);
      drive(v, w, d, r, h, f, rs, rt);
      tick();
      model_edge(v, w, d, r, h, f);
      chk($sformatf("r%0d_valid", c),    32'(bus.exwb_valid),    32'(m_valid));
      chk($sformatf("r%0d_regwrite", c), 32'(bus.exwb_regwrite), 32'(m_regwrite));
      chk($sformatf("r%0d_dst", c),      32'(bus.exwb_dst),      32'(m_dst));
      chk($sformatf("r%0d_result", c),   32'(bus.exwb_result),   32'(m_result));
      chk($sformatf("r%0d_ready", c),    32'(bus.ex_ready),      32'(!h));
      chk($sformatf("r%0d_rs", c),       32'(bus.rs_data),       32'(model_read(rs)));
      chk($sformatf("r%0d_rt", c),       32'(bus.rt_data),       32'(model_read(rt)));
      chk($sformatf("r%0d_count", c),    32'(bus.retire_count),  32'(m_count % 65536));
      chk($sformatf("r%0d_count4", c),   32'(bus4.retire_count), 32'(m_count % 16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
